// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one data-RAM port among NUM_CORES cores.
// One transaction in flight: IDLE -> ISSUE -> (WAIT x RD_LAT) -> ACK -> IDLE.
module dram_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 16,
    parameter int unsigned RD_LAT    = 1,
    localparam int unsigned GW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int unsigned CW       = $clog2(RD_LAT + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CORES-1:0]    req_i,
    input  logic [NUM_CORES-1:0]    wren_i,
    input  logic [NUM_CORES*AW-1:0] addr_i,
    input  logic [NUM_CORES*DW-1:0] wdata_i,
    output logic [NUM_CORES-1:0]    ack_o,
    output logic [DW-1:0]           rdata_o,
    output logic [AW-1:0]           mem_addr_o,
    output logic [DW-1:0]           mem_wdata_o,
    output logic                    mem_wren_o,
    input  logic [DW-1:0]           mem_rdata_i,
    output logic [GW-1:0]           grant_id_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   last_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            wren_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   rdata_q;
    logic [GW-1:0]   pick;
    logic            found;
    int unsigned     idx;

    // Round-robin pick: first set req bit searching upward from last_q+1 with wrap.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NUM_CORES; i++) begin
            idx = (int'(last_q) + i) % NUM_CORES;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // State register; reset aborts any transaction immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|req_i) state_d = StIssue;
            StIssue: state_d = wren_q ? StAck : StWait;
            StWait:  if (cnt_q == CW'(1)) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: latch the winner in IDLE, count read latency, capture read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q     <= '0;
            last_q      <= GW'(NUM_CORES - 1);
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wren_q      <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_i) begin
                        grant_q     <= pick;
                        mem_addr_q  <= addr_i[int'(pick)*AW +: AW];
                        mem_wdata_q <= wdata_i[int'(pick)*DW +: DW];
                        wren_q      <= wren_i[pick];
                    end
                end
                StIssue: cnt_q <= CW'(RD_LAT);
                StWait: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) rdata_q <= mem_rdata_i;
                end
                StAck:   last_q <= grant_q;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state so that reset clears ack and mem_wren at once.
    always_comb begin
        ack_o      = '0;
        mem_wren_o = 1'b0;
        busy_o     = (state_q != StIdle);
        if (state_q == StIssue) mem_wren_o = wren_q;
        if (state_q == StAck) ack_o[grant_q] = 1'b1;
    end

    assign rdata_o     = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3,
// each with its own RAM model; a scoreboard queue checks every ack.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [3:0]  req_v = '0;
    logic [3:0]  wren_v = '0;
    logic [63:0] addr_v = '0;
    logic [63:0] wdata_v = '0;

    logic [3:0]  req0, req1, ack0, ack1;
    logic [15:0] rd0, rd1, ma0, ma1, md0, md1, mr0, mr1;
    logic        mw0, mw1, busy0, busy1;
    logic [1:0]  gid0, gid1;

    logic [3:0]  c_ack;
    logic [15:0] c_maddr, c_mwdata;
    logic        c_wren;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          core;
        logic [15:0] rd;
    } exp_t;
    exp_t sq[$];

    typedef struct {
        bit          s;
        int          core;
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] rd;
    } vec_t;
    vec_t tbl[8];

    logic [15:0] last_rd[2];

    always #5 clk = ~clk;

    assign req0     = sel ? 4'b0 : req_v;
    assign req1     = sel ? req_v : 4'b0;
    assign c_ack    = sel ? ack1 : ack0;
    assign c_maddr  = sel ? ma1 : ma0;
    assign c_mwdata = sel ? md1 : md0;
    assign c_wren   = sel ? mw1 : mw0;

    dram_arbiter #(.NUM_CORES(4), .AW(16), .DW(16), .RD_LAT(1)) u0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .wren_i(wren_v), .addr_i(addr_v),
        .wdata_i(wdata_v), .ack_o(ack0), .rdata_o(rd0), .mem_addr_o(ma0),
        .mem_wdata_o(md0), .mem_wren_o(mw0), .mem_rdata_i(mr0), .grant_id_o(gid0),
        .busy_o(busy0)
    );

    dram_arbiter #(.NUM_CORES(4), .AW(16), .DW(16), .RD_LAT(3)) u1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .wren_i(wren_v), .addr_i(addr_v),
        .wdata_i(wdata_v), .ack_o(ack1), .rdata_o(rd1), .mem_addr_o(ma1),
        .mem_wdata_o(md1), .mem_wren_o(mw1), .mem_rdata_i(mr1), .grant_id_o(gid1),
        .busy_o(busy1)
    );

    // RAM models: synchronous write, read data delayed RD_LAT cycles after address.
    logic [15:0] m0 [256];
    logic [15:0] m1 [256];
    logic [15:0] p1 [3];
    always @(posedge clk) begin
        if (mw0) m0[ma0[7:0]] <= md0;
        mr0 <= m0[ma0[7:0]];
        if (mw1) m1[ma1[7:0]] <= md1;
        p1[0] <= m1[ma1[7:0]];
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign mr1 = p1[2];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic mon(input logic [3:0] a, input logic [1:0] g, input logic [15:0] rd);
        exp_t e;
        if (sq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got %0h want none at %0t", a, $time);
        end else begin
            e = sq.pop_front();
            chk("ack_onehot", 32'(a), 32'(1) << e.core);
            chk("grant_id", 32'(g), e.core);
            chk("rdata", 32'(rd), 32'(e.rd));
        end
    endtask

    // Scoreboard consumer: every ack pulse must match the next expected entry.
    always @(negedge clk) begin
        if (ack0 != 4'b0) mon(ack0, gid0, rd0);
        if (ack1 != 4'b0) mon(ack1, gid1, rd1);
    end

    task automatic push(input int c, input logic [15:0] rd);
        exp_t e;
        e.core = c;
        e.rd   = rd;
        sq.push_back(e);
    endtask

    // Single transaction on one instance, with cycle-exact latency checks.
    task automatic do_txn(input bit s, input int c, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rd);
        int lat;
        int cyc;
        bit done;
        lat = w ? 2 : (s ? 5 : 3);
        if (w) begin
            push(c, last_rd[s]);
        end else begin
            push(c, exp_rd);
            last_rd[s] = exp_rd;
        end
        @(posedge clk);
        #1;
        sel               = s;
        wren_v[c]         = w;
        addr_v[c*16 +: 16]  = a;
        wdata_v[c*16 +: 16] = d;
        req_v[c]          = 1'b1;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                chk("issue_wren", 32'(c_wren), 32'(w));
                chk("issue_addr", 32'(c_maddr), 32'(a));
                if (w) chk("issue_wdata", 32'(c_mwdata), 32'(d));
            end else begin
                chk("wren_idle", 32'(c_wren), 0);
            end
            if (c_ack[c]) begin
                done = 1;
                chk("latency", cyc - 1, lat);
                req_v[c] = 1'b0;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL txn_timeout: got no ack want ack core %0d", c);
            req_v[c] = 1'b0;
        end
    endtask

    // Several cores read 0x0010 on u0; keep=1 holds every req high throughout.
    task automatic multi(input logic [3:0] mask, input int n, input bit keep);
        int got;
        int cyc;
        @(posedge clk);
        #1;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wren_v[i]         = 1'b0;
            addr_v[i*16 +: 16] = 16'h0010;
        end
        req_v = mask;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ack0 != 4'b0) begin
                got++;
                if (!keep || got == n) req_v = req_v & ~ack0;
            end
        end
        req_v = '0;
        if (got < n) begin
            total++;
            bad++;
            $display("FAIL multi_timeout: got %0d acks want %0d", got, n);
        end
    endtask

    initial begin
        tbl[0] = '{s: 0, core: 0, w: 1, a: 16'h0010, d: 16'hBEEF, rd: 16'h0};
        tbl[1] = '{s: 0, core: 2, w: 0, a: 16'h0010, d: 16'h0,    rd: 16'hBEEF};
        tbl[2] = '{s: 0, core: 3, w: 1, a: 16'h0020, d: 16'h1234, rd: 16'h0};
        tbl[3] = '{s: 0, core: 1, w: 0, a: 16'h0020, d: 16'h0,    rd: 16'h1234};
        tbl[4] = '{s: 1, core: 0, w: 1, a: 16'h0030, d: 16'h5A5A, rd: 16'h0};
        tbl[5] = '{s: 1, core: 1, w: 0, a: 16'h0030, d: 16'h0,    rd: 16'h5A5A};
        tbl[6] = '{s: 1, core: 2, w: 1, a: 16'h0040, d: 16'h7777, rd: 16'h0};
        tbl[7] = '{s: 1, core: 3, w: 0, a: 16'h0040, d: 16'h0,    rd: 16'h7777};
        last_rd[0] = '0;
        last_rd[1] = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_ack", 32'(ack0), 0);
        chk("rst_wren", 32'(mw0), 0);
        chk("rst_addr", 32'(ma0), 0);
        chk("rst_rdata", 32'(rd0), 0);
        chk("rst_gid", 32'(gid0), 0);
        rst = 1'b0;

        // Table: write/read on RD_LAT=1, then RD_LAT=3 incl. write not touching rdata.
        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].s, tbl[i].core, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd);
        end

        // last_grant=1 on u0: cores 1 and 3 together -> 3 first, then 1.
        push(3, 16'hBEEF);
        push(1, 16'hBEEF);
        multi(4'b1010, 2, 1'b0);

        // Single requester is granted on every pass; leaves last_grant=3.
        push(3, 16'hBEEF);
        push(3, 16'hBEEF);
        multi(4'b1000, 2, 1'b1);

        // All requesting: grants rotate 0..3 twice.
        for (int k = 0; k < 8; k++) push(k % 4, 16'hBEEF);
        multi(4'b1111, 8, 1'b1);
        last_rd[0] = 16'hBEEF;

        // Reset during WAIT of a read: abort, no ack, outputs at reset values.
        @(posedge clk);
        #1;
        sel = 1'b0;
        wren_v[2] = 1'b0;
        addr_v[2*16 +: 16] = 16'h0010;
        req_v[2] = 1'b1;
        repeat (3) @(negedge clk);
        chk("wait_busy", 32'(busy0), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_ack", 32'(ack0), 0);
        chk("abort_wren", 32'(mw0), 0);
        chk("abort_addr", 32'(ma0), 0);
        chk("abort_wdata", 32'(md0), 0);
        chk("abort_rdata", 32'(rd0), 0);
        chk("abort_gid", 32'(gid0), 0);
        req_v = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(negedge clk);
        chk("held_ack", 32'(ack0), 0);
        rst = 1'b0;

        // After reset core 0 wins first.
        push(0, 16'hBEEF);
        push(3, 16'hBEEF);
        multi(4'b1001, 2, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
